// File: rtl/md_sched_if.sv
// Issue/result bundle between the pipeline and the multiply/divide sequencer.
interface md_sched_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_D;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        stall_md;

  modport master (
    output start, op, rs_val, rt_val, md_D,
    input  busy, hi, lo, stall_md
  );

  modport slave (
    input  start, op, rs_val, rt_val, md_D,
    output busy, hi, lo, stall_md
  );
endinterface

// File: rtl/md_sched.sv
// Multi-cycle multiply/divide sequencer: owns HI/LO, holds each MULT/DIV for a
// fixed latency and raises a stall for md-class instructions waiting in stage D.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  md_sched_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;
  logic        r_pend_wr;

  logic        w_issue;
  logic        w_done;
  logic        w_mthi;
  logic        w_mtlo;

  logic signed [63:0] w_prod_s;
  logic        [63:0] w_prod_u;
  logic               w_dz;
  logic               w_ovf;
  logic signed [31:0] w_rs_s;
  logic signed [31:0] w_den_s;
  logic        [31:0] w_den_u;
  logic signed [31:0] w_quo_s;
  logic signed [31:0] w_rem_s;
  logic        [31:0] w_quo_u;
  logic        [31:0] w_rem_u;
  logic        [31:0] w_res_hi;
  logic        [31:0] w_res_lo;
  logic               w_res_wr;

  // Divisor is forced to 1 for zero and overflow cases so the dividers never
  // see an undefined operation; those cases are resolved in the result mux.
  assign w_dz     = (bus.rt_val == 32'd0);
  assign w_ovf    = (bus.rs_val == 32'h8000_0000) && (bus.rt_val == 32'hFFFF_FFFF);
  assign w_rs_s   = $signed(bus.rs_val);
  assign w_den_s  = (w_dz || w_ovf) ? 32'sd1 : $signed(bus.rt_val);
  assign w_den_u  = w_dz ? 32'd1 : bus.rt_val;
  assign w_prod_s = $signed(bus.rs_val) * $signed(bus.rt_val);
  assign w_prod_u = {32'd0, bus.rs_val} * {32'd0, bus.rt_val};
  assign w_quo_s  = w_rs_s / w_den_s;
  assign w_rem_s  = w_rs_s % w_den_s;
  assign w_quo_u  = bus.rs_val / w_den_u;
  assign w_rem_u  = bus.rs_val % w_den_u;

  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    w_res_wr = 1'b1;
    case (bus.op)
      3'd0: {w_res_hi, w_res_lo} = w_prod_s;
      3'd1: {w_res_hi, w_res_lo} = w_prod_u;
      3'd2: begin
        if (w_ovf) begin
          w_res_hi = 32'd0;
          w_res_lo = 32'h8000_0000;
        end else begin
          w_res_hi = w_rem_s;
          w_res_lo = w_quo_s;
        end
        w_res_wr = !w_dz;
      end
      3'd3: begin
        w_res_hi = w_rem_u;
        w_res_lo = w_quo_u;
        w_res_wr = !w_dz;
      end
      default: w_res_wr = 1'b0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_done       = 1'b0;
    w_mthi       = 1'b0;
    w_mtlo       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              w_issue      = 1'b1;
              w_state_next = RUN;
            end
            3'd4:    w_mthi = 1'b1;
            3'd5:    w_mtlo = 1'b1;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (r_cnt == 4'd1) begin
          w_done       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_wr <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_issue) begin
        r_pend_hi <= w_res_hi;
        r_pend_lo <= w_res_lo;
        r_pend_wr <= w_res_wr;
        r_cnt     <= bus.op[1] ? DIV_N : MULT_N;
      end else if (r_state == RUN) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // A divide by zero still runs its full latency but leaves HI/LO alone.
      if (w_done && r_pend_wr) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end else begin
        if (w_mthi) r_hi <= bus.rs_val;
        if (w_mtlo) r_lo <= bus.rs_val;
      end
    end
  end

  assign bus.busy     = (r_state == RUN);
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign bus.stall_md = bus.md_D & ((r_state == RUN) | (bus.start & (bus.op <= 3'd3)));

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: hand-computed HI/LO results, busy latency,
// stall behaviour, ignored starts while busy and reset mid-operation.
module tb_md_sched;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  md_sched_if u_if ();

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one multi-cycle op with md_D held high; optionally pulse an MTLO
  // during busy cycle inj, which the unit must ignore.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input int n, input logic [31:0] ehi,
                        input logic [31:0] elo, input int inj);
    u_if.start  = 1'b1;
    u_if.op     = op;
    u_if.rs_val = rs;
    u_if.rt_val = rt;
    u_if.md_D   = 1'b1;
    #1;
    chk({tag, " stall_issue"}, 64'(u_if.stall_md), 64'd1);
    step();
    u_if.start  = 1'b0;
    u_if.rs_val = 32'd0;
    u_if.rt_val = 32'd0;
    for (int i = 1; i <= n; i++) begin
      chk({tag, " busy_run"}, 64'(u_if.busy), 64'd1);
      chk({tag, " stall_run"}, 64'(u_if.stall_md), 64'd1);
      chk({tag, " hi_hold"}, 64'(u_if.hi), 64'(m_hi));
      chk({tag, " lo_hold"}, 64'(u_if.lo), 64'(m_lo));
      if (i == inj) begin
        u_if.start  = 1'b1;
        u_if.op     = 3'd5;
        u_if.rs_val = 32'hDEAD_BEEF;
      end
      step();
      u_if.start = 1'b0;
    end
    chk({tag, " busy_done"}, 64'(u_if.busy), 64'd0);
    chk({tag, " stall_done"}, 64'(u_if.stall_md), 64'd0);
    chk({tag, " hi"}, 64'(u_if.hi), 64'(ehi));
    chk({tag, " lo"}, 64'(u_if.lo), 64'(elo));
    m_hi = ehi;
    m_lo = elo;
    u_if.md_D = 1'b0;
    $display("[TB] %s: hi=%h lo=%h", tag, u_if.hi, u_if.lo);
  endtask

  task automatic idle_op(input string tag, input logic [2:0] op, input logic [31:0] rs,
                         input logic [31:0] ehi, input logic [31:0] elo);
    u_if.start  = 1'b1;
    u_if.op     = op;
    u_if.rs_val = rs;
    u_if.md_D   = 1'b0;
    #1;
    chk({tag, " stall"}, 64'(u_if.stall_md), 64'd0);
    step();
    u_if.start = 1'b0;
    chk({tag, " busy"}, 64'(u_if.busy), 64'd0);
    chk({tag, " hi"}, 64'(u_if.hi), 64'(ehi));
    chk({tag, " lo"}, 64'(u_if.lo), 64'(elo));
    m_hi = ehi;
    m_lo = elo;
    $display("[TB] %s: hi=%h lo=%h", tag, u_if.hi, u_if.lo);
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    m_hi        = 32'd0;
    m_lo        = 32'd0;
    reset       = 1'b0;
    u_if.start  = 1'b0;
    u_if.op     = 3'd0;
    u_if.rs_val = 32'd0;
    u_if.rt_val = 32'd0;
    u_if.md_D   = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    chk("rst busy", 64'(u_if.busy), 64'd0);
    chk("rst hi", 64'(u_if.hi), 64'd0);
    chk("rst lo", 64'(u_if.lo), 64'd0);
    chk("rst stall", 64'(u_if.stall_md), 64'd0);
    $display("[TB] reset: busy=%0d hi=%h lo=%h", u_if.busy, u_if.hi, u_if.lo);

    run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0);
    run_op("divu", 3'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14, 0);
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    idle_op("mthi", 3'd4, 32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFD);
    run_op("div_zero", 3'd2, 32'd5, 32'd0, 10, 32'h1234_5678, 32'hFFFF_FFFD, 0);
    run_op("multu_ign", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001, 3);
    idle_op("nop6", 3'd6, 32'hAAAA_5555, 32'hFFFF_FFFE, 32'h0000_0001);
    idle_op("mtlo", 3'd5, 32'hCAFE_F00D, 32'hFFFF_FFFE, 32'hCAFE_F00D);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, 0);

    // Reset during busy cycle 2 discards the pending product.
    u_if.start  = 1'b1;
    u_if.op     = 3'd0;
    u_if.rs_val = 32'd2;
    u_if.rt_val = 32'd3;
    u_if.md_D   = 1'b0;
    #1;
    chk("rstmid stall_noD", 64'(u_if.stall_md), 64'd0);
    step();
    u_if.start = 1'b0;
    chk("rstmid busy1", 64'(u_if.busy), 64'd1);
    step();
    chk("rstmid busy2", 64'(u_if.busy), 64'd1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("rstmid busy", 64'(u_if.busy), 64'd0);
    chk("rstmid hi", 64'(u_if.hi), 64'd0);
    chk("rstmid lo", 64'(u_if.lo), 64'd0);
    repeat (8) step();
    chk("rstmid late busy", 64'(u_if.busy), 64'd0);
    chk("rstmid late hi", 64'(u_if.hi), 64'd0);
    chk("rstmid late lo", 64'(u_if.lo), 64'd0);
    $display("[TB] reset_mid_op: busy=%0d hi=%h lo=%h", u_if.busy, u_if.hi, u_if.lo);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
